// File: rtl/rename_alloc_rat.sv
// Rename allocator and register alias table fed by four interleaved freelist banks.
// Pops one preg per renamed destination, round-robin over the non-empty banks.
module rename_alloc_rat #(
  parameter int unsigned PREGWIDE = 7,
  parameter int unsigned AREGWIDE = 5,
  parameter int unsigned BANKNUM  = 4
) (
  input  logic                        Clk,
  input  logic                        Rest,
  input  logic                        RenValid,
  output logic                        RenReady,
  input  logic [AREGWIDE-1:0]         RenRj,
  input  logic [AREGWIDE-1:0]         RenRk,
  input  logic [AREGWIDE-1:0]         RenRd,
  input  logic                        RenRdWe,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [PREGWIDE-1:0]         OutPj,
  output logic [PREGWIDE-1:0]         OutPk,
  output logic [PREGWIDE-1:0]         OutPd,
  output logic [PREGWIDE-1:0]         OutOldPd,
  output logic                        OutPdValid,
  input  logic [BANKNUM*PREGWIDE-1:0] FlPreOut,
  input  logic [BANKNUM-1:0]          FlEmpty,
  output logic [BANKNUM-1:0]          FlRable,
  output logic [BANKNUM-1:0]          FlWable,
  output logic [PREGWIDE-1:0]         FlDin,
  input  logic                        CmtValid,
  input  logic                        CmtRdWe,
  input  logic [AREGWIDE-1:0]         CmtRd,
  input  logic [PREGWIDE-1:0]         CmtPd,
  input  logic [PREGWIDE-1:0]         CmtOldPd,
  input  logic                        FlushValid
);

  localparam int unsigned BankW   = $clog2(BANKNUM);
  localparam int unsigned NumAreg = 2 ** AREGWIDE;

  logic [PREGWIDE-1:0] spec_rat_q [NumAreg];
  logic [PREGWIDE-1:0] cmt_rat_q  [NumAreg];
  logic [BankW-1:0]    rr_ptr_q;

  logic [PREGWIDE-1:0] heads [BANKNUM];
  logic [PREGWIDE-1:0] head;
  logic [BankW-1:0]    chosen;
  logic [BankW-1:0]    cand;
  logic                any_free;
  logic                need_alloc;
  logic                fire;
  logic                cmt_we;

  always_comb begin
    for (int unsigned b = 0; b < BANKNUM; b++) begin
      heads[b] = FlPreOut[b*PREGWIDE +: PREGWIDE];
    end
  end

  // First non-empty bank starting at the round-robin pointer.
  always_comb begin
    chosen   = rr_ptr_q;
    cand     = '0;
    any_free = 1'b0;
    for (int unsigned k = 0; k < BANKNUM; k++) begin
      cand = rr_ptr_q + BankW'(k);
      if (!any_free && !FlEmpty[cand]) begin
        chosen   = cand;
        any_free = 1'b1;
      end
    end
  end

  assign head       = heads[chosen];
  assign need_alloc = RenRdWe && (RenRd != '0);
  assign cmt_we     = CmtValid && CmtRdWe && (CmtRd != '0);

  always_comb begin
    RenReady = Rest && !FlushValid && (!OutValid || OutReady) && (!need_alloc || any_free);
  end

  assign fire = RenValid && RenReady;

  always_comb begin
    FlRable = '0;
    if (fire && need_alloc) begin
      FlRable[chosen] = 1'b1;
    end
  end

  // Flush copies the committed table, bypassing a commit landing in the same cycle.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int unsigned i = 0; i < NumAreg; i++) begin
        spec_rat_q[i] <= PREGWIDE'(i);
      end
    end else if (FlushValid) begin
      for (int unsigned i = 0; i < NumAreg; i++) begin
        spec_rat_q[i] <= (cmt_we && (CmtRd == AREGWIDE'(i))) ? CmtPd : cmt_rat_q[i];
      end
    end else if (fire && need_alloc) begin
      spec_rat_q[RenRd] <= head;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int unsigned i = 0; i < NumAreg; i++) begin
        cmt_rat_q[i] <= PREGWIDE'(i);
      end
    end else if (cmt_we) begin
      cmt_rat_q[CmtRd] <= CmtPd;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      rr_ptr_q   <= '0;
      OutValid   <= 1'b0;
      OutPj      <= '0;
      OutPk      <= '0;
      OutPd      <= '0;
      OutOldPd   <= '0;
      OutPdValid <= 1'b0;
    end else if (fire) begin
      OutValid   <= 1'b1;
      OutPj      <= spec_rat_q[RenRj];
      OutPk      <= spec_rat_q[RenRk];
      OutOldPd   <= spec_rat_q[RenRd];
      OutPd      <= need_alloc ? head : '0;
      OutPdValid <= need_alloc;
      if (need_alloc) begin
        rr_ptr_q <= chosen + 1'b1;
      end
    end else if (FlushValid) begin
      OutValid <= 1'b0;
      rr_ptr_q <= '0;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // The superseded preg goes back to the bank selected by its low index bits.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      FlWable <= '0;
      FlDin   <= '0;
    end else if (cmt_we) begin
      FlWable                   <= '0;
      FlWable[CmtOldPd[BankW-1:0]] <= 1'b1;
      FlDin                     <= CmtOldPd;
    end else begin
      FlWable <= '0;
    end
  end

endmodule

// File: tb/tb_rename_alloc_rat.sv
// Directed bench for rename_alloc_rat: expected results go into a queue at issue time,
// a negedge monitor compares them when the DUT presents/hands off a result.
module tb_rename_alloc_rat;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        RenValid, RenReady, RenRdWe;
  logic [4:0]  RenRj, RenRk, RenRd;
  logic        OutValid, OutReady, OutPdValid;
  logic [6:0]  OutPj, OutPk, OutPd, OutOldPd;
  logic [27:0] FlPreOut;
  logic [3:0]  FlEmpty, FlRable, FlWable;
  logic [6:0]  FlDin;
  logic        CmtValid, CmtRdWe, FlushValid;
  logic [4:0]  CmtRd;
  logic [6:0]  CmtPd, CmtOldPd;

  rename_alloc_rat dut (
    .Clk(Clk), .Rest(Rest),
    .RenValid(RenValid), .RenReady(RenReady), .RenRj(RenRj), .RenRk(RenRk),
    .RenRd(RenRd), .RenRdWe(RenRdWe),
    .OutValid(OutValid), .OutReady(OutReady), .OutPj(OutPj), .OutPk(OutPk),
    .OutPd(OutPd), .OutOldPd(OutOldPd), .OutPdValid(OutPdValid),
    .FlPreOut(FlPreOut), .FlEmpty(FlEmpty), .FlRable(FlRable), .FlWable(FlWable),
    .FlDin(FlDin),
    .CmtValid(CmtValid), .CmtRdWe(CmtRdWe), .CmtRd(CmtRd), .CmtPd(CmtPd),
    .CmtOldPd(CmtOldPd), .FlushValid(FlushValid)
  );

  always #5 Clk = ~Clk;

  // Freelist head stub: each pop advances that bank to its next preg.
  logic [6:0] heads [4] = '{7'd32, 7'd33, 7'd34, 7'd35};
  assign FlPreOut = {heads[3], heads[2], heads[1], heads[0]};
  always @(posedge Clk) begin
    for (int b = 0; b < 4; b++) begin
      if (FlRable[b]) heads[b] <= heads[b] + 7'd4;
    end
  end

  typedef struct packed {
    logic [6:0] pj;
    logic [6:0] pk;
    logic [6:0] pd;
    logic [6:0] old;
    logic       pdv;
  } exp_t;

  exp_t exp_q[$];
  exp_t nxt;
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (OutValid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {31'd0, OutValid}, 32'd0);
      end else begin
        mon_e = exp_q[0];
        chk("out_pj", OutPj, mon_e.pj);
        chk("out_pk", OutPk, mon_e.pk);
        chk("out_pd", OutPd, mon_e.pd);
        chk("out_oldpd", OutOldPd, mon_e.old);
        chk("out_pdvalid", OutPdValid, mon_e.pdv);
        if (OutReady) void'(exp_q.pop_front());
      end
    end
  end

  task automatic ren(input bit v, input int rj, input int rk, input int rd, input bit we);
    RenValid = v;
    RenRj    = 5'(rj);
    RenRk    = 5'(rk);
    RenRd    = 5'(rd);
    RenRdWe  = we;
  endtask

  task automatic expect_out(input int pj, input int pk, input int pd, input int old,
                            input bit pdv);
    nxt = '{pj: 7'(pj), pk: 7'(pk), pd: 7'(pd), old: 7'(old), pdv: pdv};
  endtask

  // Called at posedge+1; checks combinational handshake then advances one cycle.
  task automatic step(input logic exp_ready, input logic [3:0] exp_rable);
    #2;
    chk("ren_ready", RenReady, exp_ready);
    chk("fl_rable", FlRable, exp_rable);
    if (RenValid && exp_ready) exp_q.push_back(nxt);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rest = 1'b0; OutReady = 1'b1; FlEmpty = 4'b0000;
    CmtValid = 1'b0; CmtRdWe = 1'b0; CmtRd = '0; CmtPd = '0; CmtOldPd = '0;
    FlushValid = 1'b0;
    ren(1, 0, 0, 5, 1);
    repeat (2) @(posedge Clk);
    #3;
    chk("rst_ren_ready", RenReady, 0);
    chk("rst_fl_rable", FlRable, 0);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_out_pd", OutPd, 0);
    chk("rst_fl_wable", FlWable, 0);
    chk("rst_fl_din", FlDin, 0);
    @(posedge Clk);
    #1;
    Rest = 1'b1;
    // First cycle out of reset can already fire.
    expect_out(0, 0, 32, 5, 1);           step(1, 4'b0001);
    ren(1, 5, 0, 6, 1);
    expect_out(32, 0, 33, 6, 1);          step(1, 4'b0010);
    ren(1, 6, 5, 7, 1);
    expect_out(33, 32, 34, 7, 1);         step(1, 4'b0100);
    ren(0, 0, 0, 0, 0);
    CmtValid = 1; CmtRdWe = 1; CmtRd = 5'd7; CmtPd = 7'd34; CmtOldPd = 7'd7;
    step(1, 4'b0000);
    CmtValid = 0; CmtRdWe = 0;
    chk("cmt_fl_wable", FlWable, 4'b1000);
    chk("cmt_fl_din", FlDin, 7);
    FlushValid = 1; ren(1, 0, 0, 14, 1);
    step(0, 4'b0000);
    FlushValid = 0;
    chk("flush_out_valid", OutValid, 0);
    chk("flush_fl_wable_clear", FlWable, 0);
    // r7 restored from committed table, r5 back to identity.
    ren(1, 7, 5, 0, 0);
    expect_out(34, 5, 0, 0, 0);           step(1, 4'b0000);
    ren(1, 0, 0, 8, 1);
    expect_out(0, 0, 36, 8, 1);           step(1, 4'b0001);
    FlEmpty = 4'b0010; ren(1, 0, 0, 10, 1);
    expect_out(0, 0, 38, 10, 1);          step(1, 4'b0100);
    FlEmpty = 4'b1111; ren(1, 0, 0, 11, 1);
    step(0, 4'b0000);
    ren(1, 8, 10, 11, 0);
    expect_out(36, 38, 0, 11, 0);         step(1, 4'b0000);
    FlEmpty = 4'b0000; ren(1, 3, 0, 3, 1);
    expect_out(3, 0, 35, 3, 1);           step(1, 4'b1000);
    expect_out(35, 0, 40, 35, 1);         step(1, 4'b0001);
    OutReady = 0; ren(1, 0, 0, 12, 1);
    repeat (3) step(0, 4'b0000);
    OutReady = 1;
    expect_out(0, 0, 37, 12, 1);          step(1, 4'b0010);
    ren(1, 0, 0, 9, 1);
    expect_out(0, 0, 42, 9, 1);           step(1, 4'b0100);
    FlushValid = 1; ren(1, 0, 0, 14, 1);
    CmtValid = 1; CmtRdWe = 1; CmtRd = 5'd20; CmtPd = 7'd77; CmtOldPd = 7'd20;
    step(0, 4'b0000);
    FlushValid = 0; CmtValid = 0; CmtRdWe = 0;
    chk("flush2_out_valid", OutValid, 0);
    chk("cmt2_fl_wable", FlWable, 4'b0001);
    chk("cmt2_fl_din", FlDin, 20);
    // r9 reverts, r20 sees the bypassed same-cycle commit, r0 allocates nothing.
    ren(1, 9, 20, 0, 1);
    expect_out(9, 77, 0, 0, 0);           step(1, 4'b0000);
    chk("cmt2_fl_wable_clear", FlWable, 0);
    ren(1, 12, 7, 1, 1);
    expect_out(12, 34, 44, 1, 1);         step(1, 4'b0001);
    ren(0, 0, 0, 0, 0);
    repeat (2) step(1, 4'b0000);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_alloc_rat.md
# rename_alloc_rat

Rename-stage allocator and register alias table that sits directly downstream of the four interleaved physical-register freelist banks. Each cycle it:
- renames one instruction: reads source mappings, pops a free physical register round-robin across the non-empty banks, records the new destination mapping;
- at commit, updates the committed alias table and returns the superseded physical register to its home bank.

Flush restores the speculative table from the committed table.

## Interface
- PREGWIDE, 7, physical register index width (128 pregs)
- AREGWIDE, 5, architectural register index width (32 aregs)
- BANKNUM, 4, number of freelist banks; bank b owns pregs with index[1:0]==b
- Clk  in  1  clock, all state on rising edge
- Rest  in  1  reset, asynchronous, active-low
- RenValid  in  1  rename request
- RenReady  out  1  rename accepted this cycle when RenValid&&RenReady (fire)
- RenRj, RenRk  in  AREGWIDE  source aregs
- RenRd  in  AREGWIDE  destination areg
- RenRdWe  in  1  instruction writes RenRd
- OutValid  out  1  renamed result valid
- OutReady  in  1  downstream accepts result
- OutPj, OutPk  out  PREGWIDE  source pregs
- OutPd, OutOldPd  out  PREGWIDE  new and previous dest preg
- OutPdValid  out  1  a preg was allocated
- FlPreOut  in  BANKNUM*PREGWIDE  head entry of each bank; bank b at [b*7+:7]
- FlEmpty  in  BANKNUM  per-bank empty
- FlRable  out  BANKNUM  per-bank pop, combinational
- FlWable  out  BANKNUM  per-bank push, registered
- FlDin  out  PREGWIDE  push data, shared
- CmtValid  in  1  commit of one instruction
- CmtRdWe  in  1  committed instruction wrote a dest
- CmtRd  in  AREGWIDE  committed dest areg
- CmtPd, CmtOldPd  in  PREGWIDE  committed new and old preg
- FlushValid  in  1  pipeline flush

## Operation
- State:
  - SpecRat[32], CmtRat[32] of PREGWIDE each.
  - Round-robin pointer RrPtr, 2 bits.
  - Output register set.
  - Push register set.
- NeedAlloc = RenRdWe && RenRd!=0. r0 is never renamed; writes to r0 allocate nothing and OutPdValid=0.
- Bank choice: first b in order RrPtr, RrPtr+1, … (mod 4) with FlEmpty[b]==0. AnyFree = some bank non-empty.
- RenReady = Rest && !FlushValid && (!OutValid || OutReady) && (!NeedAlloc || AnyFree).
- On fire:
  - OutPj/OutPk = SpecRat[RenRj]/SpecRat[RenRk].
  - OutOldPd = SpecRat[RenRd].
  - If NeedAlloc: OutPd = chosen bank head, FlRable[chosen]=1, SpecRat[RenRd] <= OutPd, RrPtr <= chosen+1.
  - Else: OutPd=0, FlRable=0, RrPtr unchanged.
- Source read is read-before-write. When RenRj==RenRd, OutPj is the old mapping.
- Output register:
  - OutValid <= 1 on fire.
  - OutValid <= 0 when OutValid&&OutReady and no fire.
  - Held stable while OutValid && !OutReady.
- Commit with CmtValid && CmtRdWe && CmtRd!=0:
  - CmtRat[CmtRd] <= CmtPd.
  - Next cycle FlWable[CmtOldPd[1:0]]=1 and FlDin=CmtOldPd.
  - Otherwise FlWable=0 next cycle.
- Flush:
  - SpecRat <= CmtRat, including a same-cycle commit (bypassed).
  - OutValid <= 0, RrPtr <= 0, no pop.
  - The commit-path push still occurs.
- Flush wins over rename in the same cycle. Commit and rename in the same cycle are independent.

## Timing
- Reset values, all asynchronous:
  - SpecRat[i]=CmtRat[i]=i.
  - RrPtr=0.
  - OutValid=0, all Out* 0.
  - FlWable=0, FlDin=0.
  - RenReady=0 and FlRable=0 while Rest low.
- Rename latency 1: fire in cycle N, result visible in cycle N+1.
- Back-to-back renames sustain 1/cycle when OutReady=1. A dependent rename in N+1 sees the mapping written in N.
- FlRable pulses exactly one cycle per fire with NeedAlloc. The freelist head advances at the same edge.
- Commit-to-push latency 1.
- Reset deasserted mid-stream: the first fire is possible in the first cycle Rest is high.

## Test plan
- Reset, then rename Rd=5, RdWe, all banks non-empty -> next cycle OutValid=1, OutPd=bank0 head (e.g. 32), OutOldPd=5, FlRable=4'b0001 during fire; a second rename of Rd=6 pops bank1.
- FlEmpty=4'b0010 with RrPtr=1 -> bank2 chosen; FlEmpty=4'b1111 with NeedAlloc -> RenReady=0, no pop; a rename with RdWe=0 still fires.
- Rename Rd=Rj=3 twice -> first OutPj=3; second OutPj=first OutPd, OutOldPd=first OutPd.
- OutReady=0 for 3 cycles with OutValid=1 -> Out* stable, RenReady=0, no FlRable.
- Rename Rd=7 (gets 34); commit Rd=7 Pd=34 OldPd=7 -> next cycle FlWable=4'b1000, FlDin=7. Then flush -> SpecRat[7]=34, OutValid=0, RrPtr=0.
- Rename Rd=9 then flush with no commit -> SpecRat[9]=9. Flush with same-cycle RenValid -> no fire, no pop. Rename Rd=0 RdWe -> OutPdValid=0, no pop.
